// File: rtl/pmem_arb_pkg.sv
// Shared types and defaults for the physical-memory port arbiter.
package pmem_arb_pkg;

  localparam int unsigned PMEM_ADDR_W = 32;
  localparam int unsigned PMEM_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_t;

  // The requester that was not the given one.
  function automatic arb_port_t other_port(input arb_port_t p);
    return (p == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/pmem_arb_pick.sv
// Combinational winner select for the pmem arbiter.
// PMEM_ARB_RR_EN defined  : round-robin on a tie, the port not granted last wins.
// PMEM_ARB_RR_EN undefined: fixed priority, D-cache over I-cache.
module pmem_arb_pick
  import pmem_arb_pkg::*;
(
  input  logic      req_i,
  input  logic      req_d,
  input  arb_port_t last_grant,
  output arb_port_t winner
);

`ifdef PMEM_ARB_RR_EN
  // Tie goes to whichever port lost the previous grant.
  always_comb begin
    winner = PORT_I;
    if (req_i && req_d) begin
      winner = other_port(last_grant);
    end else if (req_d) begin
      winner = PORT_D;
    end
  end
`else
  logic w_unused_last_grant;
  assign w_unused_last_grant = last_grant;

  // D-cache always wins when it is requesting.
  always_comb begin
    winner = PORT_I;
    if (req_d) begin
      winner = PORT_D;
    end
  end
`endif

endmodule

// File: rtl/pmem_arbiter.sv
// Shares the single physical-memory port between the I-cache and D-cache.
// One requester is granted per transaction; a dead RELEASE cycle follows
// every completion so the served cache can drop or change its request.
// Optional macro: PMEM_ARB_RR_EN selects round-robin tie-breaking
// (default build: fixed D-over-I priority).
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = PMEM_ADDR_W,
  parameter int unsigned LINE_W = PMEM_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic [LINE_W-1:0] i_pmem_wdata,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  arb_port_t  r_last_grant;
  arb_port_t  w_winner;
  logic       w_grant;
  logic       w_req_i;
  logic       w_req_d;

  assign w_req_i = i_pmem_read | i_pmem_write;
  assign w_req_d = d_pmem_read | d_pmem_write;

  // Read data is broadcast; only the resp is steered.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  pmem_arb_pick u_pick (
    .req_i      (w_req_i),
    .req_d      (w_req_d),
    .last_grant (r_last_grant),
    .winner     (w_winner)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Last granted port; only consulted when round-robin is built in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= PORT_I;
    end else if (w_grant) begin
      r_last_grant <= w_winner;
    end
  end

  // Next-state logic: grant in IDLE, hold grant until resp or drop, one dead cycle after resp.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_i || w_req_d) begin
          w_grant     = 1'b1;
          w_state_nxt = (w_winner == PORT_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        if (!w_req_i) begin
          w_state_nxt = IDLE;
        end else if (pmem_resp) begin
          w_state_nxt = RELEASE;
        end
      end
      SERVE_D: begin
        if (!w_req_d) begin
          w_state_nxt = IDLE;
        end else if (pmem_resp) begin
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory-side forwarding and resp routing from the granted port; read beats write.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    case (r_state)
      SERVE_I: begin
        pmem_read    = i_pmem_read;
        pmem_write   = i_pmem_write & ~i_pmem_read;
        pmem_address = i_pmem_address;
        pmem_wdata   = i_pmem_wdata;
        i_pmem_resp  = pmem_resp & w_req_i;
      end
      SERVE_D: begin
        pmem_read    = d_pmem_read;
        pmem_write   = d_pmem_write & ~d_pmem_read;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp & w_req_d;
      end
      default: ;
    endcase
  end

  // A cache must never ask for read and write at once.
  a_i_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_pmem_read && i_pmem_write))
    else $warning("pmem_arbiter: I-cache read and write asserted together");

  a_d_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(d_pmem_read && d_pmem_write))
    else $warning("pmem_arbiter: D-cache read and write asserted together");

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized bench for pmem_arbiter with a transaction-level reference model.
module tb_pmem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;
`ifdef PMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
  logic [ADDR_W-1:0] i_pmem_address, d_pmem_address, pmem_address;
  logic [LINE_W-1:0] i_pmem_wdata, d_pmem_wdata, pmem_wdata;
  logic [LINE_W-1:0] i_pmem_rdata, d_pmem_rdata, pmem_rdata;
  logic              i_pmem_resp, d_pmem_resp;
  logic              pmem_read, pmem_write, pmem_resp;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
    .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [255:0] wd;
    int          gap;
  } req_t;

  // Cache agents: scripted request queues, index 0 = I, 1 = D.
  req_t q_i[$];
  req_t q_d[$];
  req_t cur[2];
  logic act[2];
  logic seen[2];
  bit   abort_en;

  // Reference model: who owns the port, and the first cycle a new grant may be made.
  int m_owner;      // 0 none, 1 I, 2 D
  int m_free_at;
  int m_last;       // 1 I, 2 D

  // Memory model.
  bit mem_busy;
  int mem_cnt, mem_lat, mem_lat_fix;

  // Observed transaction log for directed ordering checks.
  logic [31:0] served_addr_q[$];
  logic [1:0]  served_op_q[$];
  int          served_cyc_q[$];
  logic        prev_active;
  int          last_i_resp_cyc, n_d_resp;

  int   cyc, n_checks, n_fail;
  logic nx_rst_n;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic advance_agent(input int p);
    req_t h;
    if (act[p] && seen[p]) act[p] = 1'b0;
    else if (act[p] && abort_en && $urandom_range(0, 29) == 0) act[p] = 1'b0;
    if (!act[p]) begin
      if (p == 0 && q_i.size() > 0) begin
        h = q_i[0];
        if (h.gap > 0) begin h.gap--; q_i[0] = h; end
        else begin cur[p] = q_i.pop_front(); act[p] = 1'b1; end
      end else if (p == 1 && q_d.size() > 0) begin
        h = q_d[0];
        if (h.gap > 0) begin h.gap--; q_d[0] = h; end
        else begin cur[p] = q_d.pop_front(); act[p] = 1'b1; end
      end
    end
  endtask

  task automatic compare();
    logic ireq, dreq, active;
    logic exp_rd, exp_wr, exp_ir, exp_dr;
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] exp_wd;
    ireq = i_pmem_read | i_pmem_write;
    dreq = d_pmem_read | d_pmem_write;
    exp_rd = 1'b0; exp_wr = 1'b0; exp_ir = 1'b0; exp_dr = 1'b0;
    exp_addr = '0; exp_wd = '0;
    if (m_owner == 1) begin
      exp_rd = i_pmem_read; exp_wr = i_pmem_write && !i_pmem_read;
      exp_addr = i_pmem_address; exp_wd = i_pmem_wdata; exp_ir = ireq && pmem_resp;
    end else if (m_owner == 2) begin
      exp_rd = d_pmem_read; exp_wr = d_pmem_write && !d_pmem_read;
      exp_addr = d_pmem_address; exp_wd = d_pmem_wdata; exp_dr = dreq && pmem_resp;
    end
    check("pmem_read", pmem_read, exp_rd);
    check("pmem_write", pmem_write, exp_wr);
    check("pmem_address", pmem_address, exp_addr);
    check("pmem_wdata", pmem_wdata, exp_wd);
    check("i_pmem_resp", i_pmem_resp, exp_ir);
    check("d_pmem_resp", d_pmem_resp, exp_dr);
    if (rst_n) begin
      check("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
      check("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
    end
    seen[0] = i_pmem_resp;
    seen[1] = d_pmem_resp;
    if (i_pmem_resp) last_i_resp_cyc = cyc;
    if (d_pmem_resp) n_d_resp++;
    active = pmem_read | pmem_write;
    if (active && !prev_active) begin
      served_addr_q.push_back(pmem_address);
      served_op_q.push_back({pmem_read, pmem_write});
      served_cyc_q.push_back(cyc);
    end
    prev_active = active;
  endtask

  task automatic update();
    logic ireq, dreq, own_req;
    if (!rst_n) begin
      m_owner = 0; m_last = 1; m_free_at = 0; mem_busy = 1'b0;
      return;
    end
    ireq = i_pmem_read | i_pmem_write;
    dreq = d_pmem_read | d_pmem_write;
    if (m_owner != 0) begin
      own_req = (m_owner == 1) ? ireq : dreq;
      if (!own_req) begin m_owner = 0; m_free_at = cyc + 1; end
      else if (pmem_resp) begin m_owner = 0; m_free_at = cyc + 2; end
    end else if (cyc >= m_free_at && (ireq || dreq)) begin
      if (ireq && dreq) m_owner = RR ? ((m_last == 1) ? 2 : 1) : 2;
      else m_owner = ireq ? 1 : 2;
      m_last = m_owner;
    end
    if (pmem_resp) mem_busy = 1'b0;
    else if (pmem_read || pmem_write) begin
      if (!mem_busy) begin
        mem_busy = 1'b1; mem_cnt = 1;
        mem_lat = (mem_lat_fix != 0) ? mem_lat_fix : $urandom_range(1, 5);
      end else mem_cnt++;
    end else mem_busy = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    rst_n = nx_rst_n;
    advance_agent(0);
    advance_agent(1);
    i_pmem_read = act[0] & cur[0].rd;  i_pmem_write = act[0] & cur[0].wr;
    i_pmem_address = cur[0].addr;      i_pmem_wdata = cur[0].wd;
    d_pmem_read = act[1] & cur[1].rd;  d_pmem_write = act[1] & cur[1].wr;
    d_pmem_address = cur[1].addr;      d_pmem_wdata = cur[1].wd;
    for (int k = 0; k < 8; k++) pmem_rdata[k*32 +: 32] = $urandom();
    pmem_resp = mem_busy && (mem_cnt >= mem_lat);
    #1;
    compare();
    update();
    cyc++;
  endtask

  task automatic drain(input int budget);
    int  n;
    logic done;
    n = 0;
    while ((q_i.size() > 0 || q_d.size() > 0 || act[0] || act[1]) && n < budget) begin
      step();
      n++;
    end
    done = (q_i.size() == 0) && (q_d.size() == 0) && !act[0] && !act[1];
    check("drain_done", done, 1'b1);
    step();
    step();
  endtask

  function automatic req_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [255:0] wd, input int gap);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = addr; r.wd = wd; r.gap = gap;
    return r;
  endfunction

  task automatic clear_log();
    served_addr_q.delete();
    served_op_q.delete();
    served_cyc_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] a5;
    int c0, nd0;
    req_t r;
    a5 = {32{8'hA5}};
    rst_n = 1'b0; nx_rst_n = 1'b0;
    i_pmem_read = 0; i_pmem_write = 0; i_pmem_address = '0; i_pmem_wdata = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    for (int p = 0; p < 2; p++) begin cur[p] = mk(0, 0, 0, 0, 0); act[p] = 0; seen[p] = 0; end
    abort_en = 0; mem_busy = 0; mem_cnt = 0; mem_lat = 1; mem_lat_fix = 0;
    m_owner = 0; m_free_at = 0; m_last = 1;
    prev_active = 0; last_i_resp_cyc = 0; n_d_resp = 0;
    cyc = 0; n_checks = 0; n_fail = 0;

    // Reset state.
    repeat (3) step();
    nx_rst_n = 1'b1;
    repeat (2) step();

    // 1: async reset in the middle of a D writeback.
    mem_lat_fix = 30;
    q_d.push_back(mk(0, 1, 32'h0000_3000, a5, 0));
    step(); step();
    check("t1_write_active", pmem_write, 1'b1);
    #2;
    rst_n = 1'b0; nx_rst_n = 1'b0;
    #1;
    check("t1_async_write_drop", pmem_write, 1'b0);
    check("t1_async_addr_drop", pmem_address, 32'h0);
    act[1] = 1'b0; q_d.delete();
    m_owner = 0; m_last = 1; m_free_at = 0; mem_busy = 1'b0;
    repeat (2) step();
    nx_rst_n = 1'b1;
    nd0 = n_d_resp;
    repeat (6) step();
    check("t1_no_spurious_resp", n_d_resp - nd0, 0);

    // 2: single I read, memory latency 5.
    clear_log();
    mem_lat_fix = 5;
    c0 = cyc;
    nd0 = n_d_resp;
    q_i.push_back(mk(1, 0, 32'h0000_1000, '0, 0));
    drain(100);
    check("t2_count", served_addr_q.size(), 1);
    check("t2_addr", served_addr_q[0], 32'h0000_1000);
    check("t2_read_latency", served_cyc_q[0] - c0, 1);
    check("t2_resp_latency", last_i_resp_cyc - c0, 6);
    check("t2_no_d_resp", n_d_resp - nd0, 0);

    // 3: simultaneous I and D reads.
    clear_log();
    mem_lat_fix = 3;
    q_i.push_back(mk(1, 0, 32'h0000_1000, '0, 0));
    q_d.push_back(mk(1, 0, 32'h0000_2000, '0, 0));
    drain(100);
    check("t3_count", served_addr_q.size(), 2);
    check("t3_first", served_addr_q[0], 32'h0000_2000);
    check("t3_second", served_addr_q[1], 32'h0000_1000);

    // 4: D writeback then line fill while I waits.
    clear_log();
    q_d.push_back(mk(0, 1, 32'h0000_3000, a5, 0));
    q_d.push_back(mk(1, 0, 32'h0000_4000, '0, 0));
    q_i.push_back(mk(1, 0, 32'h0000_5000, '0, 1));
    drain(200);
    check("t4_count", served_addr_q.size(), 3);
    check("t4_first", served_addr_q[0], 32'h0000_3000);
    check("t4_first_is_write", served_op_q[0], 2'b01);
    check("t4_second", served_addr_q[1], RR ? 32'h0000_5000 : 32'h0000_4000);
    check("t4_third", served_addr_q[2], RR ? 32'h0000_4000 : 32'h0000_5000);

    // 5: D arrives while I is served; no pre-emption.
    clear_log();
    mem_lat_fix = 4;
    q_i.push_back(mk(1, 0, 32'h0000_6000, '0, 0));
    q_d.push_back(mk(1, 0, 32'h0000_7000, '0, 2));
    drain(200);
    check("t5_count", served_addr_q.size(), 2);
    check("t5_first", served_addr_q[0], 32'h0000_6000);
    check("t5_second", served_addr_q[1], 32'h0000_7000);
    check("t5_d_start_after_iresp", served_cyc_q[1] - last_i_resp_cyc, 3);

    // 6: illegal read+write from I; read takes precedence.
    clear_log();
    q_i.push_back(mk(1, 1, 32'h0000_8000, a5, 0));
    drain(100);
    check("t6_count", served_addr_q.size(), 1);
    check("t6_addr", served_addr_q[0], 32'h0000_8000);
    check("t6_read_wins", served_op_q[0], 2'b10);

    // Random traffic with aborts and random memory latency.
    abort_en = 1; mem_lat_fix = 0;
    for (int n = 0; n < 120; n++) begin
      for (int p = 0; p < 2; p++) begin
        r.rd = 1'($urandom_range(0, 1));
        r.wr = ~r.rd;
        r.addr = {$urandom_range(0, 32'h07FF_FFFF), 5'b0};
        for (int k = 0; k < 8; k++) r.wd[k*32 +: 32] = $urandom();
        r.gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 5);
        if (p == 0) q_i.push_back(r); else q_d.push_back(r);
      end
    end
    drain(20000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
